// File: rtl/hd44780_pkg.sv
// Shared constants and FSM state encodings for the hd44780 frame scheduler slice.
package hd44780_pkg;

    localparam int         MEM_BITS   = 6;
    localparam int         LINE_WIDTH = 16;
    localparam logic [7:0] FILL_CHAR  = 8'h20;

    typedef logic [2:0] state_t;

    localparam state_t ST_CLEAR     = 3'd0;
    localparam state_t ST_IDLE      = 3'd1;
    localparam state_t ST_TRIG      = 3'd2;
    localparam state_t ST_WAIT_RISE = 3'd3;
    localparam state_t ST_WAIT_FALL = 3'd4;

endpackage

// File: rtl/hd44780_rr_arb2.sv
// Two-requester round-robin grant; the pointer flips to the other side after any grant.
module hd44780_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    logic ptr;

    // ptr only matters when both requesters are valid at once
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (en) begin
            if (valid0 && (!valid1 || !ptr)) begin
                grant0 = 1'b1;
            end else if (valid1) begin
                grant1 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (grant0) begin
            ptr <= 1'b1;
        end else if (grant1) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/hd44780_frame_scheduler.sv
// Owns the hd44780 frame buffer, arbitrates writers and decides when to fire the driver trigger.
module hd44780_frame_scheduler #(
    parameter int         MEM_BITS       = hd44780_pkg::MEM_BITS,
    parameter int         DATA_W         = 8,
    parameter logic [7:0] FILL_CHAR      = hd44780_pkg::FILL_CHAR,
    parameter int         REFRESH_CYCLES = 250000,
    parameter int         BUSY_TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [MEM_BITS-1:0] req0_addr,
    input  logic [DATA_W-1:0]   req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [MEM_BITS-1:0] req1_addr,
    input  logic [DATA_W-1:0]   req1_data,
    output logic                req1_ready,
    input  logic                lcd_busy,
    output logic                lcd_trg,
    input  logic [MEM_BITS-1:0] lcd_addr,
    output logic [DATA_W-1:0]   lcd_data,
    output logic                dirty,
    output logic                timeout_err
);

    import hd44780_pkg::*;

    localparam int DEPTH = 2 ** MEM_BITS;
    localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);
    localparam int RC_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [DATA_W-1:0]   mem [DEPTH];
    state_t              state;
    logic [MEM_BITS-1:0] clr_ptr;
    logic [TO_W-1:0]     to_cnt;
    logic [RC_W-1:0]     ref_cnt;
    logic                refresh_due;
    logic                refresh_wrap;
    logic                start;
    logic                accept_en;
    logic                grant0;
    logic                grant1;
    logic                wr_en;
    logic [MEM_BITS-1:0] wr_addr;
    logic [DATA_W-1:0]   wr_data;

    // Writes are only taken while the driver is idle and no print is about to start,
    // so the frame the driver reads never changes under it.
    assign start     = (state == ST_IDLE) && !lcd_busy && (dirty || refresh_due);
    assign accept_en = (state == ST_IDLE) && !lcd_busy && !start;

    hd44780_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (accept_en),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign lcd_trg    = (state == ST_TRIG);
    assign lcd_data   = mem[lcd_addr];

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_ptr;
        wr_data = DATA_W'(FILL_CHAR);
        if (state == ST_CLEAR) begin
            wr_en = 1'b1;
        end else if (grant0) begin
            wr_en   = 1'b1;
            wr_addr = req0_addr;
            wr_data = req0_data;
        end else if (grant1) begin
            wr_en   = 1'b1;
            wr_addr = req1_addr;
            wr_data = req1_data;
        end
    end

    // Buffer contents are deliberately not reset; the CLEAR sweep initialises them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign refresh_wrap = (REFRESH_CYCLES != 0) && (state != ST_CLEAR) &&
                          (ref_cnt == RC_W'(REFRESH_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_cnt     <= '0;
            refresh_due <= 1'b0;
        end else begin
            if ((REFRESH_CYCLES != 0) && (state != ST_CLEAR)) begin
                ref_cnt <= refresh_wrap ? '0 : ref_cnt + 1'b1;
            end
            if (refresh_wrap) begin
                refresh_due <= 1'b1;
            end else if (state == ST_TRIG) begin
                refresh_due <= 1'b0;
            end
        end
    end

    // A missed busy handshake re-marks the frame dirty so it gets printed again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_CLEAR;
            clr_ptr     <= '0;
            to_cnt      <= '0;
            dirty       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == '1) begin
                        state <= ST_IDLE;
                        dirty <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_TRIG;
                    end else if (grant0 || grant1) begin
                        dirty <= 1'b1;
                    end
                end
                ST_TRIG: begin
                    dirty  <= 1'b0;
                    to_cnt <= '0;
                    state  <= ST_WAIT_RISE;
                end
                ST_WAIT_RISE: begin
                    if (lcd_busy) begin
                        state <= ST_WAIT_FALL;
                    end else if (to_cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        dirty       <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_WAIT_FALL: begin
                    if (!lcd_busy) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_hd44780_frame_scheduler.sv
// Directed bench for hd44780_frame_scheduler: clear sweep, writes, arbitration, timeout, reset, refresh.
module tb_hd44780_frame_scheduler;

    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [5:0] req0_addr, req1_addr;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       lcd_busy;
    logic       lcd_trg;
    logic [5:0] lcd_addr;
    logic [7:0] lcd_data;
    logic       dirty;
    logic       timeout_err;

    logic       r_busy;
    logic       r_trg;
    logic       r_ready0, r_ready1;
    logic [7:0] r_data;
    logic       r_dirty;
    logic       r_err;

    int errors = 0;
    int checks = 0;

    hd44780_frame_scheduler #(
        .REFRESH_CYCLES (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .lcd_busy    (lcd_busy),
        .lcd_trg     (lcd_trg),
        .lcd_addr    (lcd_addr),
        .lcd_data    (lcd_data),
        .dirty       (dirty),
        .timeout_err (timeout_err)
    );

    hd44780_frame_scheduler #(
        .REFRESH_CYCLES (100)
    ) dut_refresh (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (1'b0),
        .req0_addr   (6'd0),
        .req0_data   (8'd0),
        .req0_ready  (r_ready0),
        .req1_valid  (1'b0),
        .req1_addr   (6'd0),
        .req1_data   (8'd0),
        .req1_ready  (r_ready1),
        .lcd_busy    (r_busy),
        .lcd_trg     (r_trg),
        .lcd_addr    (6'd0),
        .lcd_data    (r_data),
        .dirty       (r_dirty),
        .timeout_err (r_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [5:0] a0, input logic [7:0] d0,
                                 input logic v1, input logic [5:0] a1, input logic [7:0] d1);
        req0_valid = v0;
        req0_addr  = a0;
        req0_data  = d0;
        req1_valid = v1;
        req1_addr  = a1;
        req1_data  = d1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        int trg_cycle;
        int mism;
        int leak;
        int busy_left;
        int ngrant;
        int both;
        logic [3:0] grant_seq;
        int last_trg;
        int npulse;
        int min_int;
        int busy_viol;

        rst      = 1'b0;
        lcd_busy = 1'b0;
        r_busy   = 1'b0;
        lcd_addr = 6'd0;
        applyStimulus(1'b1, 6'd0, 8'h00, 1'b1, 6'd0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_trg", lcd_trg, 0);
        checkOutput("reset_ready0", req0_ready, 0);
        checkOutput("reset_ready1", req1_ready, 0);
        checkOutput("reset_dirty", dirty, 0);
        checkOutput("reset_timeout_err", timeout_err, 0);
        applyStimulus(1'b0, 6'd0, 8'h00, 1'b0, 6'd0, 8'h00);
        #1;
        rst = 1'b1;

        // CLEAR sweep: 64 edges of fill, one IDLE edge, then the trigger
        $display("[TB] clear sweep and first trigger");
        trg_cycle = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (i == 3) begin
                checkOutput("data_during_clear_addr0", lcd_data, 8'h20);
            end
            if (lcd_trg) begin
                trg_cycle = i;
                break;
            end
        end
        checkOutput("first_trg_cycle", trg_cycle, 65);
        lcd_busy = 1'b1;
        repeat (5) tick();
        lcd_busy = 1'b0;
        repeat (2) tick();
        checkOutput("after_print_dirty", dirty, 0);
        checkOutput("after_print_trg", lcd_trg, 0);
        mism = 0;
        for (int a = 0; a < 64; a++) begin
            lcd_addr = 6'(a);
            #1;
            if (lcd_data !== 8'h20) mism++;
        end
        checkOutput("fill_readback_mismatches", mism, 0);

        $display("[TB] single write from requester 0");
        tick();
        applyStimulus(1'b1, 6'd5, 8'h41, 1'b0, 6'd0, 8'h00);
        #1;
        checkOutput("wr_ready0", req0_ready, 1);
        checkOutput("wr_ready1", req1_ready, 0);
        tick();
        applyStimulus(1'b0, 6'd5, 8'h41, 1'b0, 6'd0, 8'h00);
        checkOutput("wr_dirty_next", dirty, 1);
        checkOutput("wr_trg_not_yet", lcd_trg, 0);
        tick();
        checkOutput("wr_trg_pulse", lcd_trg, 1);
        lcd_busy = 1'b1;
        applyStimulus(1'b1, 6'd5, 8'hEE, 1'b1, 6'd7, 8'h77);
        leak = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (req0_ready || req1_ready) leak++;
        end
        checkOutput("ready_while_busy", leak, 0);
        applyStimulus(1'b0, 6'd0, 8'h00, 1'b0, 6'd0, 8'h00);
        lcd_busy = 1'b0;
        repeat (2) tick();
        checkOutput("wr_dirty_cleared", dirty, 0);
        lcd_addr = 6'd5;
        #1;
        checkOutput("wr_data_addr5", lcd_data, 8'h41);

        // The pointer favours requester 1 here because requester 0 took the last grant
        $display("[TB] round-robin arbitration");
        applyStimulus(1'b1, 6'd1, 8'h31, 1'b1, 6'd2, 8'h32);
        busy_left = 0;
        ngrant    = 0;
        both      = 0;
        grant_seq = 4'b0000;
        for (int c = 0; c < 400 && ngrant < 4; c++) begin
            if (lcd_trg) busy_left = 4;
            lcd_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            #1;
            if (req0_ready && req1_ready) both++;
            if (req0_ready || req1_ready) begin
                grant_seq[3 - ngrant] = req1_ready;
                ngrant++;
            end
            tick();
        end
        applyStimulus(1'b0, 6'd0, 8'h00, 1'b0, 6'd0, 8'h00);
        for (int c = 0; c < 20; c++) begin
            if (lcd_trg) busy_left = 4;
            lcd_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            tick();
        end
        lcd_busy = 1'b0;
        checkOutput("arb_grant_count", ngrant, 4);
        checkOutput("arb_grant_sequence", grant_seq, 4'b1010);
        checkOutput("arb_double_grant", both, 0);
        lcd_addr = 6'd1;
        #1;
        checkOutput("arb_data_addr1", lcd_data, 8'h31);
        lcd_addr = 6'd2;
        #1;
        checkOutput("arb_data_addr2", lcd_data, 8'h32);

        $display("[TB] busy never rises after trigger");
        applyStimulus(1'b1, 6'd10, 8'h55, 1'b0, 6'd0, 8'h00);
        tick();
        applyStimulus(1'b0, 6'd0, 8'h00, 1'b0, 6'd0, 8'h00);
        tick();
        checkOutput("timeout_trg", lcd_trg, 1);
        tick();
        repeat (15) tick();
        checkOutput("timeout_not_early", timeout_err, 0);
        tick();
        checkOutput("timeout_err_set", timeout_err, 1);
        checkOutput("timeout_dirty", dirty, 1);
        checkOutput("timeout_trg_low", lcd_trg, 0);
        tick();
        checkOutput("timeout_retry_trg", lcd_trg, 1);
        lcd_busy = 1'b1;
        repeat (4) tick();
        lcd_busy = 1'b0;
        repeat (2) tick();
        checkOutput("timeout_err_sticky", timeout_err, 1);
        checkOutput("retry_dirty_cleared", dirty, 0);

        $display("[TB] reset during WAIT_FALL");
        applyStimulus(1'b1, 6'd20, 8'h66, 1'b0, 6'd0, 8'h00);
        tick();
        applyStimulus(1'b0, 6'd0, 8'h00, 1'b0, 6'd0, 8'h00);
        tick();
        lcd_busy = 1'b1;
        tick();
        tick();
        #1;
        rst = 1'b0;
        applyStimulus(1'b1, 6'd3, 8'h00, 1'b0, 6'd0, 8'h00);
        #1;
        checkOutput("midrst_trg", lcd_trg, 0);
        checkOutput("midrst_ready0", req0_ready, 0);
        checkOutput("midrst_dirty", dirty, 0);
        checkOutput("midrst_timeout_err", timeout_err, 0);
        applyStimulus(1'b0, 6'd0, 8'h00, 1'b0, 6'd0, 8'h00);
        lcd_busy = 1'b0;
        rst      = 1'b1;
        tick();
        lcd_addr = 6'd1;
        #1;
        checkOutput("clear_restart_addr1_old", lcd_data, 8'h31);
        lcd_addr = 6'd20;
        #1;
        checkOutput("clear_restart_addr20_old", lcd_data, 8'h66);
        tick();
        lcd_addr = 6'd1;
        #1;
        checkOutput("clear_restart_addr1_filled", lcd_data, 8'h20);

        // Refresh instance: the bench acts as the driver, holding busy 60 cycles per print
        $display("[TB] periodic refresh");
        busy_left = 0;
        last_trg  = -1;
        npulse    = 0;
        min_int   = 1000;
        busy_viol = 0;
        for (int c = 0; c < 700; c++) begin
            if (r_trg) begin
                if (r_busy) busy_viol++;
                if (last_trg >= 0 && (c - last_trg) < min_int) min_int = c - last_trg;
                last_trg  = c;
                npulse++;
                busy_left = 60;
            end
            r_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            tick();
        end
        checkOutput("refresh_pulse_count_min6", (npulse >= 6) ? 1 : 0, 1);
        checkOutput("refresh_min_interval", min_int, 100);
        checkOutput("refresh_trg_while_busy", busy_viol, 0);
        checkOutput("refresh_no_timeout", r_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
